// File: rtl/instruction_memory_param.sv
// Parametrised instruction store: registered fetch with misaligned/out-of-range
// fault reporting, and a sequential word loader that fills the array at run time.
module instruction_memory_param #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] PC,
  input  logic                  fetch_req,
  input  logic                  stall,
  output logic [DATA_WIDTH-1:0] Inst,
  output logic                  inst_valid,
  output logic                  misaligned,
  output logic                  out_of_range,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  loading,
  output logic                  load_done
);

  // Handshake: a fetch is accepted on a rising edge when state is READY,
  // stall=0, fetch_req=1 and load_start=0; its result is presented with
  // inst_valid=1 on the following cycle and held while stall=1. A load word
  // is accepted on any rising edge in LOADING with load_valid=1; there is no
  // backpressure on the loader.

  localparam int                    IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-3:0] DEPTH_W  = (ADDR_WIDTH - 2)'(DEPTH);

  typedef enum logic {
    READY   = 1'b0,
    LOADING = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]   inst_q, inst_d;
  logic                    valid_q, valid_d;
  logic                    mis_q, mis_d;
  logic                    oor_q, oor_d;
  logic                    load_done_q, load_done_d;

  logic                    mem_we;
  logic [IDX_W-1:0]        wr_idx;
  logic                    load_last;
  logic [ADDR_WIDTH-3:0]   word_idx;

  // Contents survive reset; the initialiser only gives simulation a defined start.
  logic [DATA_WIDTH-1:0]   mem [DEPTH] = '{default: NOP_WORD};

  // State register and fetch/loader flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= READY;
      ptr_q       <= '0;
      inst_q      <= NOP_WORD;
      valid_q     <= 1'b0;
      mis_q       <= 1'b0;
      oor_q       <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      inst_q      <= inst_d;
      valid_q     <= valid_d;
      mis_q       <= mis_d;
      oor_q       <= oor_d;
      load_done_q <= load_done_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we && !reset) begin
      mem[wr_idx] <= load_data;
    end
  end

  // Next-state and loader pointer.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mem_we    = 1'b0;
    wr_idx    = ptr_q;
    load_last = 1'b0;
    unique case (state_q)
      READY: begin
        if (load_start) begin
          state_d = LOADING;
          ptr_d   = '0;
        end
      end
      LOADING: begin
        // A restart rewinds first, so a same-cycle word lands at index 0.
        wr_idx = load_start ? '0 : ptr_q;
        ptr_d  = wr_idx;
        if (load_valid) begin
          mem_we = 1'b1;
          if (wr_idx == LAST_IDX) begin
            state_d   = READY;
            ptr_d     = '0;
            load_last = 1'b1;
          end else begin
            ptr_d = wr_idx + IDX_W'(1);
          end
        end
      end
    endcase
  end

  // Fetch result and fault flags.
  always_comb begin
    inst_d      = inst_q;
    valid_d     = valid_q;
    mis_d       = mis_q;
    oor_d       = oor_q;
    load_done_d = load_last;
    word_idx    = PC[ADDR_WIDTH-1:2];
    if (state_q == LOADING || load_start) begin
      valid_d = 1'b0;
      mis_d   = 1'b0;
      oor_d   = 1'b0;
    end else if (!stall) begin
      valid_d = fetch_req;
      mis_d   = 1'b0;
      oor_d   = 1'b0;
      if (fetch_req) begin
        if (PC[1:0] != 2'b00) begin
          inst_d = NOP_WORD;
          mis_d  = 1'b1;
        end else if (word_idx >= DEPTH_W) begin
          inst_d = NOP_WORD;
          oor_d  = 1'b1;
        end else begin
          inst_d = mem[word_idx[IDX_W-1:0]];
        end
      end
    end
  end

  assign Inst         = inst_q;
  assign inst_valid   = valid_q;
  assign misaligned   = mis_q;
  assign out_of_range = oor_q;
  assign loading      = (state_q == LOADING);
  assign load_done    = load_done_q;

endmodule

// File: doc/instruction_memory_param.md
Name: instruction_memory_param

Overview:
Parametrised successor to the fixed 32x32 instruction store. It holds DEPTH words of DATA_WIDTH bits and serves registered fetches with a valid/stall handshake. Out-of-range and misaligned PCs are reported as faults instead of reading undefined locations. The program is loaded at run time through a sequential word loader rather than fixed at elaboration. It sits between the PC register and the IF/ID pipeline register.

Parameters:
DATA_WIDTH, 32, instruction word width in bits
ADDR_WIDTH, 32, PC width in bits (byte address)
DEPTH, 32, number of instruction words; need not be a power of two
NOP_WORD, 0, word driven on Inst for a fault or after reset

Ports:
clock  input  1  system clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset
PC  input  ADDR_WIDTH  byte address of the fetch
fetch_req  input  1  fetch request; sampled when stall=0
stall  input  1  pipeline stall; holds all fetch outputs
Inst  output  DATA_WIDTH  fetched instruction (registered)
inst_valid  output  1  Inst holds the result of an accepted fetch
misaligned  output  1  accepted fetch had PC[1:0] != 0
out_of_range  output  1  accepted fetch had word index >= DEPTH
load_start  input  1  enter or restart program load at word 0
load_valid  input  1  load_data is valid this cycle
load_data  input  DATA_WIDTH  word to write
loading  output  1  loader is active; fetch is blocked
load_done  output  1  one-cycle pulse after the last word is written

Behaviour:
- Reset (synchronous, active-high):
  - Inst=NOP_WORD; inst_valid, misaligned, out_of_range, loading and load_done are all 0.
  - State=READY; load pointer=0.
  - Memory contents are NOT cleared. In simulation, memory initialises to NOP_WORD.
- States: READY and LOADING. The loading output equals (state==LOADING).
- READY, load_start=1 -> LOADING with pointer=0. load_start has priority over a same-cycle fetch_req. That fetch is dropped and inst_valid=0 on the next cycle.
- LOADING, load_valid=1:
  - mem[pointer] <= load_data; pointer increments.
  - If pointer was DEPTH-1: state -> READY, pointer -> 0, load_done=1 for exactly one cycle.
- LOADING, load_start=1: pointer -> 0 and the state stays LOADING. If load_valid is also 1, the word is written to index 0 and pointer -> 1.
- LOADING, load_valid=0: no change.
- Fetch outputs while LOADING: inst_valid=0, no fault flags set, fetch_req ignored, stall ignored, Inst holds its value.
- Fetch in READY, stall=0, fetch_req=1: results appear one cycle later (1-cycle latency).
  - Word index = PC[ADDR_WIDTH-1:2].
  - If PC[1:0] != 0: Inst=NOP_WORD, misaligned=1, inst_valid=1.
  - Else if index >= DEPTH: Inst=NOP_WORD, out_of_range=1, inst_valid=1.
  - Else: Inst=mem[index], inst_valid=1, both faults 0.
  - If both fault conditions hold, misaligned=1 and out_of_range=0.
- READY, stall=0, fetch_req=0: inst_valid=0, faults cleared, Inst holds.
- stall=1 in READY: Inst, inst_valid and both faults hold. fetch_req is ignored. load_start is still honoured.
- Back-to-back fetches with stall=0 sustain one result per cycle.
- No read/write collision is possible, since fetches are blocked while LOADING.
- Reset mid-load: returns to READY; words already written are retained. No load_done pulse.

Test Plan:
1. Reset, then fetch PC=0 -> next cycle Inst=0x00000000 (initial NOP), inst_valid=1, no faults.
2. load_start, then 32 load_valid beats with data 0x10000000+i -> loading=1 throughout; load_done pulses once, one cycle after the 32nd beat; loading=0. Fetch PC=0x14 -> Inst=0x10000005 one cycle later; back-to-back PC=0x18, 0x1C -> 0x10000006, 0x10000007 on consecutive cycles.
3. Fetch PC=0x16 -> Inst=0, misaligned=1. Fetch PC=0x80 -> Inst=0, out_of_range=1. Fetch PC=0x82 -> misaligned=1, out_of_range=0.
4. Fetch PC=0x08 (Inst=0x10000002), then stall=1 for 3 cycles with PC=0x0C -> Inst, inst_valid and faults unchanged. Release stall -> Inst=0x10000003.
5. load_start with fetch_req=1 in the same cycle -> inst_valid=0 next cycle, loading=1. Write 5 words, assert reset -> loading=0, no load_done. Fetch PC=0x10 -> new word 4 data; PC=0x14 -> old 0x10000005.
6. Mid-load load_start restart after 10 words -> the next word lands at index 0. load_done fires only after 32 further beats.
